// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the exception control slice.
// ExcCode values, exception vector offsets, the exception record carried
// down the pipeline, and the controller state type.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_CPU  = 5'd11;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VEC_OFF_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_OFF_INT     = 32'h0000_0200;
    localparam logic [31:0] VEC_OFF_GENERAL = 32'h0000_0180;
    // With BEV=1 the exception vectors sit 0x200 above the boot base.
    localparam logic [31:0] BEV_BASE_OFF    = 32'h0000_0200;

    // Oldest fault of one instruction, carried IF -> MEM.
    typedef struct packed {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic [31:0] badva;
        logic        refill;
        logic [1:0]  copNum;
    } excRec_t;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_FLUSH,
        ST_ERET
    } excState_t;

    // Drop the fault of a record whose instruction is being flushed.
    function automatic excRec_t killRec(input excRec_t rec, input logic kill);
        excRec_t r;
        r = rec;
        if (kill) begin
            r.exc = 1'b0;
        end
        return r;
    endfunction

    // Codes that report a faulting virtual address to BadVAddr.
    function automatic logic isAddrCode(input logic [4:0] code);
        return (code >= EXC_MOD) && (code <= EXC_ADES);
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: exchange between the exception controller and CP0.
// master = exception controller side, slave = CP0 side.
interface exc_ctrl_if;

    logic        interrupt;
    logic        statusEXL;
    logic        statusERL;
    logic        statusBEV;
    logic        causeIV;
    logic [31:0] regEPCOut;
    logic [31:0] regErrorEPCOut;

    logic        excAccept;
    logic [31:0] regEPCIn;
    logic        bdIn;
    logic [4:0]  excCodeIn;
    logic [1:0]  copNum;
    logic [31:0] badVAddrIn;
    logic        writeBadVAddr;

    modport master (
        input  interrupt, statusEXL, statusERL, statusBEV, causeIV,
        input  regEPCOut, regErrorEPCOut,
        output excAccept, regEPCIn, bdIn, excCodeIn, copNum,
        output badVAddrIn, writeBadVAddr
    );

    modport slave (
        output interrupt, statusEXL, statusERL, statusBEV, causeIV,
        output regEPCOut, regErrorEPCOut,
        input  excAccept, regEPCIn, bdIn, excCodeIn, copNum,
        input  badVAddrIn, writeBadVAddr
    );

endinterface

// File: rtl/exc_vector.sv
// exc_vector: exception vector address from BEV/EXL/IV, code and refill.
// Build option EXC_TLB_REFILL_EN enables the dedicated TLB refill vector.
module exc_vector
    import exc_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
    parameter logic [31:0] KSEG0_VEC = 32'h8000_0000
) (
    input  logic        statusBEV,
    input  logic        statusEXL,
    input  logic        causeIV,
    input  logic [4:0]  code,
    input  logic        refill,
    output logic [31:0] vector
);

    logic        takeRefill;
    logic [31:0] base;
    logic [31:0] offset;

    // Select base and offset, then form the vector.
    always_comb begin
`ifdef EXC_TLB_REFILL_EN
        takeRefill = refill && !statusEXL && ((code == EXC_TLBL) || (code == EXC_TLBS));
`else
        // Refill and EXL have no influence on the vector in this build.
        takeRefill = 1'b0 & refill & ~statusEXL;
`endif
        base = statusBEV ? (RESET_VEC + BEV_BASE_OFF) : KSEG0_VEC;
        if (takeRefill) begin
            offset = VEC_OFF_REFILL;
        end else if ((code == EXC_INT) && causeIV) begin
            offset = VEC_OFF_INT;
        end else begin
            offset = VEC_OFF_GENERAL;
        end
        vector = base + offset;
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception control unit for the 5-stage MIPS pipeline.
// Carries the oldest fault to MEM, commits it (or an interrupt) to CP0,
// flushes the pipeline and redirects fetch to the vector or to EPC on ERET.
// Build option EXC_TLB_REFILL_EN (see exc_vector) enables the refill vector.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
    parameter logic [31:0] KSEG0_VEC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              if_valid,
    input  logic              id_valid,
    input  logic              ex_valid,
    input  logic              mem_valid,
    input  logic [31:0]       if_pc,
    input  logic              id_bd,
    input  logic              if_adel,
    input  logic              if_tlbl,
    input  logic              if_tlbRefill,
    input  logic              id_ri,
    input  logic              id_sys,
    input  logic              id_bp,
    input  logic              id_cpu,
    input  logic [1:0]        id_copNum,
    input  logic              ex_ov,
    input  logic              mem_adel,
    input  logic              mem_ades,
    input  logic              mem_tlbl,
    input  logic              mem_tlbs,
    input  logic              mem_mod,
    input  logic              mem_tlbRefill,
    input  logic [31:0]       mem_addr,
    input  logic              eret,
    exc_ctrl_if.master        cp0,
    output logic [3:0]        flush,
    output logic              redirect,
    output logic [31:0]       redirectPC
);

    excState_t   state, stateNext;
    excRec_t     ifRec, idOut, exOut, memOut;
    excRec_t     idRec, exRec, memRec;
    logic        commit;
    logic        eretTake;
    logic [4:0]  commitCode;
    logic        commitRefill;
    logic [31:0] vector;
    logic [31:0] redirPCReg;

    // IF: start a record with the fetch PC and any fetch fault.
    always_comb begin
        ifRec       = '0;
        ifRec.pc    = if_pc;
        ifRec.badva = if_pc;
        if (if_valid && if_adel) begin
            ifRec.exc  = 1'b1;
            ifRec.code = EXC_ADEL;
        end else if (if_valid && if_tlbl) begin
            ifRec.exc    = 1'b1;
            ifRec.code   = EXC_TLBL;
            ifRec.refill = if_tlbRefill;
        end
    end

    // ID: tag delay slot and add decode faults (CpU > RI > Sys > Bp).
    always_comb begin
        idOut    = idRec;
        idOut.bd = id_bd;
        if (id_valid && !idRec.exc) begin
            if (id_cpu) begin
                idOut.exc    = 1'b1;
                idOut.code   = EXC_CPU;
                idOut.copNum = id_copNum;
            end else if (id_ri) begin
                idOut.exc  = 1'b1;
                idOut.code = EXC_RI;
            end else if (id_sys) begin
                idOut.exc  = 1'b1;
                idOut.code = EXC_SYS;
            end else if (id_bp) begin
                idOut.exc  = 1'b1;
                idOut.code = EXC_BP;
            end
        end
    end

    // EX: add arithmetic overflow.
    always_comb begin
        exOut = exRec;
        if (ex_valid && !exRec.exc && ex_ov) begin
            exOut.exc  = 1'b1;
            exOut.code = EXC_OV;
        end
    end

    // MEM: add data-side faults (AdEL > AdES > TLBL > TLBS > Mod).
    always_comb begin
        memOut = memRec;
        if (mem_valid && !memRec.exc) begin
            if (mem_adel) begin
                memOut.exc   = 1'b1;
                memOut.code  = EXC_ADEL;
                memOut.badva = mem_addr;
            end else if (mem_ades) begin
                memOut.exc   = 1'b1;
                memOut.code  = EXC_ADES;
                memOut.badva = mem_addr;
            end else if (mem_tlbl) begin
                memOut.exc    = 1'b1;
                memOut.code   = EXC_TLBL;
                memOut.badva  = mem_addr;
                memOut.refill = mem_tlbRefill;
            end else if (mem_tlbs) begin
                memOut.exc    = 1'b1;
                memOut.code   = EXC_TLBS;
                memOut.badva  = mem_addr;
                memOut.refill = mem_tlbRefill;
            end else if (mem_mod) begin
                memOut.exc   = 1'b1;
                memOut.code  = EXC_MOD;
                memOut.badva = mem_addr;
            end
        end
    end

    // Stage registers: advance unless stalled. A flushed instruction loses
    // its fault whether it moves on (source stage flushed) or is held in
    // place by the stall (own stage flushed).
    always_ff @(posedge clk) begin
        if (rst) begin
            idRec  <= '0;
            exRec  <= '0;
            memRec <= '0;
        end else if (stall) begin
            idRec  <= killRec(idRec, flush[1]);
            exRec  <= killRec(exRec, flush[2]);
            memRec <= killRec(memRec, flush[3]);
        end else begin
            idRec  <= killRec(ifRec, flush[0]);
            exRec  <= killRec(idOut, flush[1]);
            memRec <= killRec(exOut, flush[2]);
        end
    end

    // Commit decision in MEM; interrupt overrides any carried fault.
    always_comb begin
        commit       = !rst && (state == ST_NORMAL) && mem_valid
                       && (cp0.interrupt || memOut.exc);
        commitCode   = cp0.interrupt ? EXC_INT : memOut.code;
        commitRefill = !cp0.interrupt && memOut.refill;
        eretTake     = !rst && (state == ST_NORMAL) && eret && !commit;
    end

    exc_vector #(
        .RESET_VEC (RESET_VEC),
        .KSEG0_VEC (KSEG0_VEC)
    ) uVector (
        .statusBEV (cp0.statusBEV),
        .statusEXL (cp0.statusEXL),
        .causeIV   (cp0.causeIV),
        .code      (commitCode),
        .refill    (commitRefill),
        .vector    (vector)
    );

    // Same-cycle CP0 update strobes on commit.
    always_comb begin
        cp0.excAccept     = commit;
        cp0.writeBadVAddr = commit && isAddrCode(commitCode);
        cp0.badVAddrIn    = memOut.badva;
        cp0.copNum        = (commit && (commitCode == EXC_CPU)) ? memOut.copNum : 2'b00;
    end

    // Latch EPC/BD/ExcCode and the redirect target at commit or ERET.
    always_ff @(posedge clk) begin
        if (rst) begin
            cp0.regEPCIn  <= '0;
            cp0.bdIn      <= 1'b0;
            cp0.excCodeIn <= '0;
            redirPCReg    <= '0;
        end else if (commit) begin
            cp0.regEPCIn  <= memOut.bd ? (memOut.pc - 32'd4) : memOut.pc;
            cp0.bdIn      <= memOut.bd;
            cp0.excCodeIn <= commitCode;
            redirPCReg    <= vector;
        end else if (eretTake) begin
            redirPCReg    <= cp0.statusERL ? cp0.regErrorEPCOut : cp0.regEPCOut;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_NORMAL;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: commit beats a same-cycle ERET; both redirects last one cycle.
    always_comb begin
        stateNext = state;
        case (state)
            ST_NORMAL: begin
                if (commit) begin
                    stateNext = ST_FLUSH;
                end else if (eretTake) begin
                    stateNext = ST_ERET;
                end
            end
            ST_FLUSH: stateNext = ST_NORMAL;
            ST_ERET:  stateNext = ST_NORMAL;
            default:  stateNext = ST_NORMAL;
        endcase
    end

    // Flush and redirect outputs per state.
    always_comb begin
        flush      = '0;
        redirect   = 1'b0;
        redirectPC = '0;
        case (state)
            ST_FLUSH: begin
                flush      = 4'b1111;
                redirect   = 1'b1;
                redirectPC = redirPCReg;
            end
            ST_ERET: begin
                flush      = 4'b0011;
                redirect   = 1'b1;
                redirectPC = redirPCReg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl with directed vectors.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        if_valid, id_valid, ex_valid, mem_valid;
    logic [31:0] if_pc;
    logic        id_bd, if_adel, if_tlbl, if_tlbRefill;
    logic        id_ri, id_sys, id_bp, id_cpu;
    logic [1:0]  id_copNum;
    logic        ex_ov;
    logic        mem_adel, mem_ades, mem_tlbl, mem_tlbs, mem_mod, mem_tlbRefill;
    logic [31:0] mem_addr;
    logic        eret;
    logic [3:0]  flush;
    logic        redirect;
    logic [31:0] redirectPC;

    exc_ctrl_if cp0If();

    exc_ctrl #(
        .RESET_VEC (32'hBFC0_0000),
        .KSEG0_VEC (32'h8000_0000)
    ) dut (
        .clk (clk), .rst (rst), .stall (stall),
        .if_valid (if_valid), .id_valid (id_valid), .ex_valid (ex_valid), .mem_valid (mem_valid),
        .if_pc (if_pc), .id_bd (id_bd),
        .if_adel (if_adel), .if_tlbl (if_tlbl), .if_tlbRefill (if_tlbRefill),
        .id_ri (id_ri), .id_sys (id_sys), .id_bp (id_bp), .id_cpu (id_cpu), .id_copNum (id_copNum),
        .ex_ov (ex_ov),
        .mem_adel (mem_adel), .mem_ades (mem_ades), .mem_tlbl (mem_tlbl), .mem_tlbs (mem_tlbs),
        .mem_mod (mem_mod), .mem_tlbRefill (mem_tlbRefill), .mem_addr (mem_addr),
        .eret (eret),
        .cp0 (cp0If.master),
        .flush (flush), .redirect (redirect), .redirectPC (redirectPC)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  flush;
        logic [31:0] pc;
        logic        isExc;
        logic [31:0] epc;
        logic        bd;
        logic [4:0]  code;
    } redirExp_t;

    typedef struct {
        string       name;
        logic        wbv;
        logic [31:0] badva;
        logic [1:0]  cop;
    } accExp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
        logic        ifAdel, ifTlbl, ifRefill;
        logic        idCpu, idRi, idSys, idBp;
        logic [1:0]  copNum;
        logic        exOv;
        logic        memAdel, memAdes, memTlbl, memTlbs, memMod, memRefill;
        logic [31:0] memAddr;
        logic        intr, eretAtMem, rstInFlush;
    } instr_t;

    redirExp_t redirQ[$];
    accExp_t   accQ[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic pushAcc(input string name, input logic wbv, input logic [31:0] badva,
                           input logic [1:0] cop);
        accExp_t a;
        a.name = name; a.wbv = wbv; a.badva = badva; a.cop = cop;
        accQ.push_back(a);
    endtask

    task automatic pushRedir(input string name, input logic [3:0] fl, input logic [31:0] pc,
                             input logic isExc, input logic [31:0] epc, input logic bd,
                             input logic [4:0] code);
        redirExp_t r;
        r.name = name; r.flush = fl; r.pc = pc; r.isExc = isExc;
        r.epc = epc; r.bd = bd; r.code = code;
        redirQ.push_back(r);
    endtask

    task automatic setStatus(input logic bev, input logic exl, input logic erl, input logic iv);
        cp0If.statusBEV = bev;
        cp0If.statusEXL = exl;
        cp0If.statusERL = erl;
        cp0If.causeIV   = iv;
    endtask

    // Monitor: pops the scoreboard whenever the DUT commits or redirects.
    initial begin
        accExp_t   a;
        redirExp_t r;
        forever begin
            @(negedge clk);
            if (cp0If.excAccept === 1'b1) begin
                if (accQ.size() == 0) begin
                    chk("unexpected_excAccept", 32'd1, 32'd0);
                end else begin
                    a = accQ.pop_front();
                    chk({a.name, "_writeBadVAddr"}, {31'd0, cp0If.writeBadVAddr}, {31'd0, a.wbv});
                    if (a.wbv) begin
                        chk({a.name, "_badVAddrIn"}, cp0If.badVAddrIn, a.badva);
                    end
                    chk({a.name, "_copNum"}, {30'd0, cp0If.copNum}, {30'd0, a.cop});
                end
            end
            if (redirect === 1'b1) begin
                if (redirQ.size() == 0) begin
                    chk("unexpected_redirect", redirectPC, 32'd0);
                end else begin
                    r = redirQ.pop_front();
                    chk({r.name, "_flush"}, {28'd0, flush}, {28'd0, r.flush});
                    chk({r.name, "_redirectPC"}, redirectPC, r.pc);
                    if (r.isExc) begin
                        chk({r.name, "_regEPCIn"}, cp0If.regEPCIn, r.epc);
                        chk({r.name, "_bdIn"}, {31'd0, cp0If.bdIn}, {31'd0, r.bd});
                        chk({r.name, "_excCodeIn"}, {27'd0, cp0If.excCodeIn}, {27'd0, r.code});
                    end
                end
            end
        end
    end

    task automatic checkAllZero(input string name);
        chk({name, "_flush"}, {28'd0, flush}, 32'd0);
        chk({name, "_redirect"}, {31'd0, redirect}, 32'd0);
        chk({name, "_redirectPC"}, redirectPC, 32'd0);
        chk({name, "_excAccept"}, {31'd0, cp0If.excAccept}, 32'd0);
        chk({name, "_writeBadVAddr"}, {31'd0, cp0If.writeBadVAddr}, 32'd0);
        chk({name, "_regEPCIn"}, cp0If.regEPCIn, 32'd0);
        chk({name, "_bdIn"}, {31'd0, cp0If.bdIn}, 32'd0);
        chk({name, "_excCodeIn"}, {27'd0, cp0If.excCodeIn}, 32'd0);
    endtask

    // Walk one instruction IF -> ID -> EX -> MEM with its stage faults.
    task automatic sendInstr(input instr_t ins);
        @(posedge clk); #1;
        if_valid = 1'b1; if_pc = ins.pc;
        if_adel = ins.ifAdel; if_tlbl = ins.ifTlbl; if_tlbRefill = ins.ifRefill;
        @(posedge clk); #1;
        if_valid = 1'b0; if_adel = 1'b0; if_tlbl = 1'b0; if_tlbRefill = 1'b0;
        id_valid = 1'b1; id_bd = ins.bd;
        id_cpu = ins.idCpu; id_ri = ins.idRi; id_sys = ins.idSys; id_bp = ins.idBp;
        id_copNum = ins.copNum;
        @(posedge clk); #1;
        id_valid = 1'b0; id_bd = 1'b0; id_cpu = 1'b0; id_ri = 1'b0; id_sys = 1'b0; id_bp = 1'b0;
        id_copNum = 2'd0;
        ex_valid = 1'b1; ex_ov = ins.exOv;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_ov = 1'b0;
        mem_valid = 1'b1; mem_addr = ins.memAddr;
        mem_adel = ins.memAdel; mem_ades = ins.memAdes; mem_tlbl = ins.memTlbl;
        mem_tlbs = ins.memTlbs; mem_mod = ins.memMod; mem_tlbRefill = ins.memRefill;
        cp0If.interrupt = ins.intr; eret = ins.eretAtMem;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_adel = 1'b0; mem_ades = 1'b0; mem_tlbl = 1'b0;
        mem_tlbs = 1'b0; mem_mod = 1'b0; mem_tlbRefill = 1'b0; mem_addr = '0;
        cp0If.interrupt = 1'b0; eret = 1'b0;
        if (ins.rstInFlush) begin
            rst = 1'b1;
            @(posedge clk); #1;
            checkAllZero("rst_in_flush");
            rst = 1'b0;
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic sendEret(input logic erl);
        cp0If.statusERL      = erl;
        cp0If.regEPCOut      = 32'h8000_2000;
        cp0If.regErrorEPCOut = 32'h8000_5000;
        @(posedge clk); #1;
        eret = 1'b1;
        @(posedge clk); #1;
        eret = 1'b0;
        cp0If.regEPCOut      = 32'hDEAD_0000;
        cp0If.regErrorEPCOut = 32'hDEAD_0004;
        repeat (3) @(posedge clk);
        cp0If.statusERL = 1'b0;
    endtask

    initial begin
        instr_t ins;
        rst = 1'b1; stall = 1'b0;
        if_valid = 1'b0; id_valid = 1'b0; ex_valid = 1'b0; mem_valid = 1'b0;
        if_pc = '0; id_bd = 1'b0; if_adel = 1'b0; if_tlbl = 1'b0; if_tlbRefill = 1'b0;
        id_ri = 1'b0; id_sys = 1'b0; id_bp = 1'b0; id_cpu = 1'b0; id_copNum = '0;
        ex_ov = 1'b0;
        mem_adel = 1'b0; mem_ades = 1'b0; mem_tlbl = 1'b0; mem_tlbs = 1'b0; mem_mod = 1'b0;
        mem_tlbRefill = 1'b0; mem_addr = '0; eret = 1'b0;
        cp0If.interrupt = 1'b0;
        cp0If.regEPCOut = '0; cp0If.regErrorEPCOut = '0;
        setStatus(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk); #1;
        checkAllZero("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Overflow in EX, BEV=0.
        ins = '0; ins.pc = 32'h8000_1000; ins.exOv = 1'b1;
        pushAcc("ov", 1'b0, 32'h0, 2'd0);
        pushRedir("ov", 4'hF, 32'h8000_0180, 1'b1, 32'h8000_1000, 1'b0, 5'd12);
        sendInstr(ins);

        // Load address error in a delay slot.
        ins = '0; ins.pc = 32'h8000_0204; ins.bd = 1'b1; ins.memAdel = 1'b1; ins.memAddr = 32'h3;
        pushAcc("adel", 1'b1, 32'h3, 2'd0);
        pushRedir("adel", 4'hF, 32'h8000_0180, 1'b1, 32'h8000_0200, 1'b1, 5'd4);
        sendInstr(ins);

        // Fetch TLB miss with EXL=0.
        ins = '0; ins.pc = 32'h0040_0000; ins.ifTlbl = 1'b1; ins.ifRefill = 1'b1;
        pushAcc("iftlbl", 1'b1, 32'h0040_0000, 2'd0);
`ifdef EXC_TLB_REFILL_EN
        pushRedir("iftlbl", 4'hF, 32'h8000_0000, 1'b1, 32'h0040_0000, 1'b0, 5'd2);
`else
        pushRedir("iftlbl", 4'hF, 32'h8000_0180, 1'b1, 32'h0040_0000, 1'b0, 5'd2);
`endif
        sendInstr(ins);

        // Interrupt with IV=1, BEV=1 overrides a carried RI.
        setStatus(1'b1, 1'b0, 1'b0, 1'b1);
        ins = '0; ins.pc = 32'h8000_3000; ins.idRi = 1'b1; ins.intr = 1'b1;
        pushAcc("intr", 1'b0, 32'h0, 2'd0);
        pushRedir("intr", 4'hF, 32'hBFC0_0400, 1'b1, 32'h8000_3000, 1'b0, 5'd0);
        sendInstr(ins);
        setStatus(1'b0, 1'b0, 1'b0, 1'b0);

        // ERET with ERL=0 then ERL=1; target sampled in the eret cycle.
        pushRedir("eret0", 4'b0011, 32'h8000_2000, 1'b0, 32'h0, 1'b0, 5'd0);
        sendEret(1'b0);
        pushRedir("eret1", 4'b0011, 32'h8000_5000, 1'b0, 32'h0, 1'b0, 5'd0);
        sendEret(1'b1);

        // CpU beats RI in ID; copNum is reported.
        ins = '0; ins.pc = 32'h8000_A000; ins.idCpu = 1'b1; ins.idRi = 1'b1; ins.copNum = 2'd2;
        pushAcc("cpu", 1'b0, 32'h0, 2'd2);
        pushRedir("cpu", 4'hF, 32'h8000_0180, 1'b1, 32'h8000_A000, 1'b0, 5'd11);
        sendInstr(ins);

        // Store TLB miss with EXL=1 always takes the general vector.
        setStatus(1'b0, 1'b1, 1'b0, 1'b0);
        ins = '0; ins.pc = 32'h8000_7000; ins.memTlbs = 1'b1; ins.memRefill = 1'b1;
        ins.memAddr = 32'h7FFF_0010;
        pushAcc("tlbs_exl", 1'b1, 32'h7FFF_0010, 2'd0);
        pushRedir("tlbs_exl", 4'hF, 32'h8000_0180, 1'b1, 32'h8000_7000, 1'b0, 5'd3);
        sendInstr(ins);

        // MEM priority AdES > TLBS > Mod, BEV=1, delay slot.
        setStatus(1'b1, 1'b0, 1'b0, 1'b0);
        ins = '0; ins.pc = 32'h8000_8000; ins.bd = 1'b1; ins.memAdes = 1'b1; ins.memTlbs = 1'b1;
        ins.memMod = 1'b1; ins.memAddr = 32'h1000_0002;
        pushAcc("ades", 1'b1, 32'h1000_0002, 2'd0);
        pushRedir("ades", 4'hF, 32'hBFC0_0380, 1'b1, 32'h8000_7FFC, 1'b1, 5'd5);
        sendInstr(ins);
        setStatus(1'b0, 1'b0, 1'b0, 1'b0);

        // Earlier-stage fault (RI) wins over a later MEM fault.
        ins = '0; ins.pc = 32'h8000_9000; ins.idRi = 1'b1; ins.memAdel = 1'b1; ins.memAddr = 32'h1;
        pushAcc("ri_old", 1'b0, 32'h0, 2'd0);
        pushRedir("ri_old", 4'hF, 32'h8000_0180, 1'b1, 32'h8000_9000, 1'b0, 5'd10);
        sendInstr(ins);

        // ERET coincident with a commit is dropped.
        cp0If.regEPCOut = 32'h8000_2000;
        ins = '0; ins.pc = 32'h8000_B000; ins.exOv = 1'b1; ins.eretAtMem = 1'b1;
        pushAcc("eret_vs_exc", 1'b0, 32'h0, 2'd0);
        pushRedir("eret_vs_exc", 4'hF, 32'h8000_0180, 1'b1, 32'h8000_B000, 1'b0, 5'd12);
        sendInstr(ins);

        // Reset asserted during FLUSH.
        ins = '0; ins.pc = 32'h8000_C000; ins.exOv = 1'b1; ins.rstInFlush = 1'b1;
        pushAcc("rstflush", 1'b0, 32'h0, 2'd0);
        pushRedir("rstflush", 4'hF, 32'h8000_0180, 1'b1, 32'h8000_C000, 1'b0, 5'd12);
        sendInstr(ins);

        repeat (3) @(posedge clk);
        chk("accQ_drained", accQ.size(), 32'd0);
        chk("redirQ_drained", redirQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception control unit for the 5-stage MIPS pipeline: it collects per-stage exception flags, carries the oldest one down to MEM with its PC and delay-slot flag, and commits exceptions and interrupts there. On commit it drives the CP0 hardware-update inputs (EPC, BD, ExcCode, BadVAddr, CE) and flushes the pipeline. It also redirects fetch to the exception vector, or to EPC/ErrorEPC on ERET. It is the consumer of CP0's status/EPC outputs and the producer of CP0's exception inputs.

## Interface
Parameters:
- RESET_VEC, 32'hBFC00000, boot base used when Status.BEV=1.
- KSEG0_VEC, 32'h80000000, exception base used when Status.BEV=0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline hold. Stage registers keep their contents.
- if_valid, id_valid, ex_valid, mem_valid  in  1 each  stage holds a live instruction.
- if_pc  in  32  fetch PC. id_bd  in  1  ID instruction is in a delay slot.
- if_adel, if_tlbl  in  1 each  fetch address error / fetch TLB miss-or-invalid. if_tlbRefill  in  1  the fetch TLB fault is a miss.
- id_ri, id_sys, id_bp, id_cpu  in  1 each  reserved instr / syscall / break / coprocessor unusable. id_copNum  in  2  coprocessor number.
- ex_ov  in  1  arithmetic overflow.
- mem_adel, mem_ades, mem_tlbl, mem_tlbs, mem_mod  in  1 each  data-side faults. mem_tlbRefill  in  1. mem_addr  in  32  data virtual address.
- eret  in  1  ERET in EX.
- interrupt, statusEXL, statusERL, statusBEV, causeIV  in  1 each  from CP0.
- regEPCOut, regErrorEPCOut  in  32  from CP0.
- excAccept  out  1  commit pulse (combinational).
- regEPCIn  out  32. bdIn  out  1. excCodeIn  out  5. copNum  out  2.
- badVAddrIn  out  32. writeBadVAddr  out  1.
- flush  out  4  {MEM,EX,ID,IF} flush.
- redirect  out  1. redirectPC  out  32.

## Operation
- ExcCodes: Int 0, Mod 1, TLBL 2, TLBS 3, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, CpU 11, Ov 12.
- Each instruction carries {exc, code[4:0], pc, bd, badva, refill, copNum} from IF to MEM. Each stage adds its own fault only when no earlier fault is recorded. Within ID, priority is CpU > RI > Sys > Bp. Within MEM, priority is AdEL > AdES > TLBL > TLBS > Mod.
- Commit in MEM when mem_valid and (interrupt or carried/MEM fault). Interrupt wins over all others with code 0. Commit ignores stall.
- On commit, in the same cycle:
  - excAccept=1.
  - writeBadVAddr=1 for codes 1–5, with badVAddrIn = mem_addr for MEM faults or the fetch PC for IF faults.
  - copNum = the carried copNum for CpU, else 0.
- regEPCIn, bdIn and excCodeIn are registered at the commit edge and held until the next commit. EPC = pc−4 when bd=1, else pc.
- FSM states:
  - NORMAL → FLUSH on commit.
  - NORMAL → ERET on eret with no commit.
  - FLUSH → NORMAL after 1 cycle.
  - ERET → NORMAL after 1 cycle.
- In FLUSH: flush=4'b1111, redirect=1, redirectPC = vector latched at commit.
- In ERET: flush=4'b0011, redirect=1, redirectPC = statusERL ? regErrorEPCOut : regEPCOut, sampled in the eret cycle.
- Vector = base + offset:
  - base = statusBEV ? RESET_VEC+32'h200 : KSEG0_VEC.
  - offset = 0x000 for refill with statusEXL=0 (see Configuration); 0x200 for interrupt with causeIV=1; else 0x180.
- Simultaneous commit and eret: commit wins and the eret is dropped. Commit in FLUSH/ERET states is impossible because flush invalidates the stages. Any such event is ignored.

## Timing
- Reset values:
  - state NORMAL, all carried exception bits 0.
  - regEPCIn=0, bdIn=0, excCodeIn=0.
  - excAccept=0, writeBadVAddr=0, flush=0, redirect=0, redirectPC=0.
- Stage registers advance on !stall. Flush clears the exc bit of the targeted stages on the same edge.
- Commit-to-redirect latency is 1 cycle. ERET-to-redirect latency is 1 cycle.
- Reset mid-FLUSH returns to NORMAL with outputs at reset values on the next edge.

## Configuration
- EXC_TLB_REFILL_EN defined: a TLB miss (refill=1) taken with statusEXL=0 uses offset 0x000.
- EXC_TLB_REFILL_EN undefined: every TLB exception uses offset 0x180, and the refill inputs are ignored.

## Structure
- Package exc_pkg holds the ExcCode localparams, the vector offsets, and a packed struct for the carried exception record.
- One sub-module, exc_vector: combinational vector computation from BEV/EXL/IV/code/refill.

## Test plan
- ex_ov at pc=32'h80001000, bd=0, BEV=0 → excAccept in MEM, then excCodeIn=12, regEPCIn=32'h80001000, redirectPC=32'h80000180, flush=4'hF.
- mem_adel, mem_addr=32'h00000003, bd=1, pc=32'h80000204 → writeBadVAddr=1, badVAddrIn=3, bdIn=1, regEPCIn=32'h80000200.
- if_tlbl with refill=1, EXL=0, BEV=0 → redirectPC=32'h80000000 with the macro, 32'h80000180 without.
- interrupt=1 with IV=1, BEV=1, plus a carried RI on the same instruction → code 0, redirectPC=32'hBFC00400.
- eret with ERL=0, regEPCOut=32'h80002000 → redirect=1 next cycle, redirectPC=32'h80002000, flush=4'b0011. Same with ERL=1 → redirectPC = regErrorEPCOut.
- eret in the same cycle as a MEM commit → only the exception redirect occurs. rst asserted in FLUSH → all outputs 0 next cycle.
